// File: rtl/dispatch_fifo.sv
// rtl/dispatch_fifo.sv - two-lane in / two-lane out decoded-instruction dispatch FIFO (optional DISPATCH_FIFO_PERF_EN full-stall counter)
module dispatch_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int REQ_MARGIN = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [1:0]                   enqueue_en,
  input  logic [DATA_WIDTH-1:0]        enqueue_data1,
  input  logic [DATA_WIDTH-1:0]        enqueue_data2,
  output logic [1:0]                   enqueue_ack,
  input  logic [1:0]                   invalid_en,
  output logic [DATA_WIDTH-1:0]        dequeue_data1,
  output logic [DATA_WIDTH-1:0]        dequeue_data2,
  output logic [1:0]                   dequeue_valid,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty,
  output logic                         get_data_req,
  output logic [31:0]                  perf_full_cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(REQ_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         head;
  logic [AW-1:0]         tail;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         free;
  logic [1:0]            ack;
  logic [1:0]            acc_cnt;
  logic [1:0]            pop_req;
  logic [1:0]            pop_cnt;
  logic                  wr0_en;
  logic                  wr1_en;
  logic [DATA_WIDTH-1:0] wr0_data;
  logic [AW-1:0]         head_p1;
  logic [AW-1:0]         tail_p1;

  // Free space comes from the registered count only; pops this cycle never make room.
  assign free    = DEPTH_C - count_q;
  assign head_p1 = head + AW'(1);
  assign tail_p1 = tail + AW'(1);

  // Grant lanes oldest-first within the free space; nothing is accepted during flush or reset.
  always_comb begin
    ack = 2'b00;
    if (!rst && !flush) begin
      if (enqueue_en[0]) begin
        ack[0] = (free >= CW'(1));
        ack[1] = enqueue_en[1] && (free >= CW'(2));
      end else begin
        ack[1] = enqueue_en[1] && (free >= CW'(1));
      end
    end
  end

  assign enqueue_ack = ack;
  assign acc_cnt     = {1'b0, ack[0]} + {1'b0, ack[1]};
  assign pop_req     = {1'b0, invalid_en[0]} + {1'b0, invalid_en[1]};
  assign pop_cnt     = (count_q < CW'(pop_req)) ? count_q[1:0] : pop_req;

  // Compaction: the first accepted lane lands at tail, the second (if any) at tail+1.
  assign wr0_en   = |ack;
  assign wr1_en   = &ack;
  assign wr0_data = ack[0] ? enqueue_data1 : enqueue_data2;

  // Storage array is not reset; slots outside the valid window are masked on read.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[tail] <= wr0_data;
    if (wr1_en) mem[tail_p1] <= enqueue_data2;
  end

  // Pointer and occupancy update; flush wins over any enqueue or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + AW'(pop_cnt);
      tail    <= tail + AW'(acc_cnt);
      count_q <= count_q + CW'(acc_cnt) - CW'(pop_cnt);
    end
  end

  assign count            = count_q;
  assign empty            = (count_q == '0);
  assign full             = (count_q == DEPTH_C);
  assign get_data_req     = (free >= MARGIN_C) && !flush;
  assign dequeue_valid[0] = (count_q >= CW'(1));
  assign dequeue_valid[1] = (count_q >= CW'(2));
  assign dequeue_data1    = dequeue_valid[0] ? mem[head]    : '0;
  assign dequeue_data2    = dequeue_valid[1] ? mem[head_p1] : '0;

`ifdef DISPATCH_FIFO_PERF_EN
  logic [31:0] perf_q;

  // Count cycles where the front end wants to write but the queue is full; survives flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (full && (enqueue_en != 2'b00) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_full_cycles = perf_q;
`else
  assign perf_full_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_dispatch_fifo.sv
// tb/tb_dispatch_fifo.sv - directed self-checking bench for dispatch_fifo
module tb_dispatch_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  enqueue_en = 2'b00;
  logic [63:0] enqueue_data1 = '0;
  logic [63:0] enqueue_data2 = '0;
  logic [1:0]  enqueue_ack;
  logic [1:0]  invalid_en = 2'b00;
  logic [63:0] dequeue_data1;
  logic [63:0] dequeue_data2;
  logic [1:0]  dequeue_valid;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        get_data_req;
  logic [31:0] perf_full_cycles;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] A = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] B = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] C = 64'hCCCC_0000_0000_000C;
  localparam logic [63:0] D = 64'hDDDD_0000_0000_000D;
  localparam logic [63:0] E = 64'hEEEE_0000_0000_000E;
  localparam logic [63:0] F = 64'hFFFF_0000_0000_000F;
  localparam logic [63:0] G = 64'h1111_0000_0000_0010;
  localparam logic [63:0] H = 64'h2222_0000_0000_0011;
  localparam logic [63:0] I = 64'h3333_0000_0000_0012;
  localparam logic [63:0] J = 64'h4444_0000_0000_0013;
  localparam logic [63:0] K = 64'h5555_0000_0000_0014;
  localparam logic [63:0] Z = 64'h6666_0000_0000_0015;

`ifdef DISPATCH_FIFO_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd4;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  dispatch_fifo #(.DATA_WIDTH(64), .DEPTH(8), .REQ_MARGIN(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .enqueue_en       (enqueue_en),
    .enqueue_data1    (enqueue_data1),
    .enqueue_data2    (enqueue_data2),
    .enqueue_ack      (enqueue_ack),
    .invalid_en       (invalid_en),
    .dequeue_data1    (dequeue_data1),
    .dequeue_data2    (dequeue_data2),
    .dequeue_valid    (dequeue_valid),
    .count            (count),
    .full             (full),
    .empty            (empty),
    .get_data_req     (get_data_req),
    .perf_full_cycles (perf_full_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] en, input logic [63:0] d1, input logic [63:0] d2,
                       input logic [1:0] inv, input logic fl);
    enqueue_en    = en;
    enqueue_data1 = d1;
    enqueue_data2 = d2;
    invalid_en    = inv;
    flush         = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] v0, v1;

    // Reset state, with a write request held so the forced-zero ack is visible.
    drive(2'b11, A, B, 2'b00, 1'b0);
    #3;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_dv", 64'(dequeue_valid), 64'd0);
    chk("rst_dd1", dequeue_data1, 64'd0);
    chk("rst_dd2", dequeue_data2, 64'd0);
    chk("rst_gdr", 64'(get_data_req), 64'd1);
    chk("rst_ack", 64'(enqueue_ack), 64'd0);
    chk("rst_perf", 64'(perf_full_cycles), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two-lane write from empty.
    drive(2'b11, A, B, 2'b00, 1'b0);
    #1 chk("ab_ack", 64'(enqueue_ack), 64'd3);
    tick();
    chk("ab_count", 64'(count), 64'd2);
    chk("ab_dd1", dequeue_data1, A);
    chk("ab_dd2", dequeue_data2, B);
    chk("ab_dv", 64'(dequeue_valid), 64'd3);

    // Fill up to seven entries.
    drive(2'b11, C, D, 2'b00, 1'b0); tick();
    drive(2'b11, E, F, 2'b00, 1'b0); tick();
    drive(2'b01, G, 64'd0, 2'b00, 1'b0); tick();
    chk("c7_count", 64'(count), 64'd7);
    chk("c7_gdr", 64'(get_data_req), 64'd0);

    // One free slot, two lanes requested: only lane 0 goes in.
    drive(2'b11, H, I, 2'b00, 1'b0);
    #1 chk("c7_ack", 64'(enqueue_ack), 64'd1);
    tick();
    chk("c8_count", 64'(count), 64'd8);
    chk("c8_full", 64'(full), 64'd1);
    chk("c8_gdr", 64'(get_data_req), 64'd0);

    // Full with simultaneous pop: pops do not create same-cycle space.
    drive(2'b11, I, J, 2'b11, 1'b0);
    #1 chk("full_pop_ack", 64'(enqueue_ack), 64'd0);
    tick();
    chk("full_pop_count", 64'(count), 64'd6);
    chk("full_pop_dd1", dequeue_data1, C);
    chk("full_pop_dd2", dequeue_data2, D);

    // Lane-1-only write and lane-1-only pop each move one entry.
    drive(2'b10, 64'd0, J, 2'b10, 1'b0);
    #1 chk("l1_ack", 64'(enqueue_ack), 64'd2);
    tick();
    chk("l1_count", 64'(count), 64'd6);
    chk("l1_dd1", dequeue_data1, D);
    chk("l1_dd2", dequeue_data2, E);

    // Drop to five, then flush while writing.
    drive(2'b00, 64'd0, 64'd0, 2'b01, 1'b0); tick();
    chk("c5_count", 64'(count), 64'd5);
    drive(2'b11, K, Z, 2'b00, 1'b1);
    #1 chk("flush_ack", 64'(enqueue_ack), 64'd0);
    chk("flush_gdr", 64'(get_data_req), 64'd0);
    tick();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_dd1", dequeue_data1, 64'd0);
    chk("flush_dd2", dequeue_data2, 64'd0);
    drive(2'b00, 64'd0, 64'd0, 2'b00, 1'b0);
    #1 chk("post_flush_gdr", 64'(get_data_req), 64'd1);

    // Pop clamping: two pops requested with a single entry held.
    drive(2'b01, K, 64'd0, 2'b11, 1'b0); tick();
    chk("k_count", 64'(count), 64'd1);
    chk("k_dv", 64'(dequeue_valid), 64'd1);
    chk("k_dd1", dequeue_data1, K);
    chk("k_dd2", dequeue_data2, 64'd0);
    drive(2'b00, 64'd0, 64'd0, 2'b11, 1'b0); tick();
    chk("clamp_count", 64'(count), 64'd0);

    // 20 cycles of 2-in/2-out: pointers wrap several times, order preserved.
    for (int i = 0; i < 20; i++) begin
      v0 = 64'hC0DE_0000_0000_0000 | 64'(2 * i);
      v1 = 64'hC0DE_0000_0000_0000 | 64'(2 * i + 1);
      drive(2'b11, v0, v1, 2'b11, 1'b0);
      tick();
      chk($sformatf("wrap%0d_count", i), 64'(count), 64'd2);
      chk($sformatf("wrap%0d_dd1", i), dequeue_data1, v0);
      chk($sformatf("wrap%0d_dd2", i), dequeue_data2, v1);
    end
    drive(2'b00, 64'd0, 64'd0, 2'b11, 1'b0); tick();
    chk("drain_empty", 64'(empty), 64'd1);

    // Reset asserted in the middle of a write cycle.
    drive(2'b11, A, B, 2'b00, 1'b0);
    #2 rst = 1'b1;
    #1 chk("midrst_ack", 64'(enqueue_ack), 64'd0);
    tick();
    chk("midrst_count", 64'(count), 64'd0);
    rst = 1'b0;
    drive(2'b01, Z, 64'd0, 2'b00, 1'b0); tick();
    chk("postrst_count", 64'(count), 64'd1);
    chk("postrst_dd1", dequeue_data1, Z);

    // Fill to full, then hold a write request for four full cycles.
    drive(2'b11, A, B, 2'b00, 1'b0); tick();
    drive(2'b11, C, D, 2'b00, 1'b0); tick();
    drive(2'b11, E, F, 2'b00, 1'b0); tick();
    drive(2'b01, G, 64'd0, 2'b00, 1'b0); tick();
    chk("perf_full", 64'(full), 64'd1);
    chk("perf_pre", 64'(perf_full_cycles), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, H, 64'd0, 2'b00, 1'b0);
      tick();
    end
    drive(2'b00, 64'd0, 64'd0, 2'b00, 1'b0);
    chk("perf_cnt", 64'(perf_full_cycles), 64'(PERF_EXP));
    chk("perf_hold_dd1", dequeue_data1, Z);
    drive(2'b00, 64'd0, 64'd0, 2'b00, 1'b1); tick();
    drive(2'b00, 64'd0, 64'd0, 2'b00, 1'b0);
    chk("perf_after_flush", 64'(perf_full_cycles), 64'(PERF_EXP));
    chk("perf_flush_empty", 64'(empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
